// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out
// frame, device ack check and bus release, with a watchdog on device clocking.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic [7:0] cmd,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t state_q, state_d;

    logic clk_m_q, clk_m_d;
    logic clk_s_q, clk_s_d;
    logic clk_p_q, clk_p_d;
    logic dat_m_q, dat_m_d;
    logic dat_s_q, dat_s_d;

    logic [9:0]       frame_q, frame_d;
    logic [3:0]       bit_q, bit_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic clk_oe_q, clk_oe_d;
    logic data_oe_q, data_oe_d;
    logic done_q, done_d;
    logic error_q, error_d;

    logic neg;
    logic active;
    logic tmo_hit;
    logic ack_bad;
    logic rel_ok;
    logic tmo_err;

    assign neg     = clk_p_q & ~clk_s_q;
    assign active  = (state_q == S_SEND) || (state_q == S_ACK) ||
                     (state_q == S_RELEASE);
    assign tmo_hit = (tmo_q == TMO_LAST);
    assign ack_bad = (state_q == S_ACK) && neg && dat_s_q;
    assign rel_ok  = (state_q == S_RELEASE) && clk_s_q && dat_s_q;
    // A device edge restarts the watchdog, so it wins over an expiry.
    assign tmo_err = active && tmo_hit && !neg && !rel_ok;

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (send) state_d = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (inh_q == INH_LAST) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                if (neg && bit_q == 4'd9) state_d = S_ACK;
                else if (tmo_err)         state_d = S_IDLE;
            end
            S_ACK: begin
                if (neg)          state_d = dat_s_q ? S_IDLE : S_RELEASE;
                else if (tmo_err) state_d = S_IDLE;
            end
            S_RELEASE: begin
                if (rel_ok || tmo_err) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = rel_ok;
        error_d   = ack_bad | tmo_err;
        unique case (state_d)
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
            end
            S_REQ: begin
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b1;
            end
            S_SEND: begin
                if (state_q == S_SEND && neg) data_oe_d = ~frame_q[bit_q];
                else                          data_oe_d = data_oe_q;
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        clk_m_d = ps2_clk;
        clk_s_d = clk_m_q;
        clk_p_d = clk_s_q;
        dat_m_d = ps2_data;
        dat_s_d = dat_m_q;
    end

    always_comb begin
        frame_d = frame_q;
        if (state_q == S_IDLE && send) frame_d = {1'b1, ~^cmd, cmd};

        bit_d = '0;
        if (state_q == S_SEND) begin
            bit_d = bit_q;
            if (neg && bit_q != 4'd9) bit_d = bit_q + 4'd1;
        end

        inh_d = '0;
        if (state_q == S_INHIBIT && inh_q != INH_LAST) begin
            inh_d = inh_q + INH_W'(1);
        end

        // Cleared outside the clocked phases, which covers SEND entry.
        tmo_d = '0;
        if (active && !neg) begin
            tmo_d = tmo_hit ? tmo_q : tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            clk_m_q   <= 1'b1;
            clk_s_q   <= 1'b1;
            clk_p_q   <= 1'b1;
            dat_m_q   <= 1'b1;
            dat_s_q   <= 1'b1;
            frame_q   <= '0;
            bit_q     <= '0;
            inh_q     <= '0;
            tmo_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            clk_m_q   <= clk_m_d;
            clk_s_q   <= clk_s_d;
            clk_p_q   <= clk_p_d;
            dat_m_q   <= dat_m_d;
            dat_s_q   <= dat_s_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            inh_q     <= inh_d;
            tmo_q     <= tmo_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on the open-drain lines, vector table,
// random transfers against a frame model, and timeout/reset corner cases.
module tb_ps2_host_tx;

    localparam int INH      = 40;
    localparam int TMO      = 500;
    localparam int HP       = 15;
    localparam int WAIT_MAX = 400;
    localparam int IDLE_MAX = 200;

    logic       CLK50MHZ;
    logic       RST;
    logic [7:0] cmd;
    logic       send;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk_low;
    logic       dev_data_low;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_both   = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK50MHZ   (CLK50MHZ),
        .RST        (RST),
        .cmd        (cmd),
        .send       (send),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Open-drain wired lines with pull-ups.
    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    initial CLK50MHZ = 1'b0;
    always #10 CLK50MHZ = ~CLK50MHZ;

    always @(negedge CLK50MHZ) begin
        if (done) n_done++;
        if (error) n_err++;
        if (done && error) n_both++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [7:0] cmd;
        logic       ack;
        logic       exp_par;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    function automatic logic [9:0] model_frame(input logic [7:0] c);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(c[i]);
        p = (ones % 2 == 0);
        return {1'b1, p, c};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK50MHZ);
            #1;
        end
    endtask

    task automatic start_send(input logic [7:0] c);
        tick(1);
        cmd  = c;
        send = 1'b1;
        tick(1);
        send = 1'b0;
    endtask

    task automatic wait_send(output bit ok);
        int n;
        n = 0;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0 && busy) &&
               n < WAIT_MAX) begin
            tick(1);
            n++;
        end
        ok = (n < WAIT_MAX);
    endtask

    task automatic dev_pulses(input int n);
        repeat (n) begin
            dev_clk_low = 1'b1;
            tick(HP);
            dev_clk_low = 1'b0;
            tick(HP);
        end
    endtask

    task automatic dev_xfer(input bit ack, output logic [9:0] got,
                            output bit ok);
        got = '0;
        wait_send(ok);
        if (!ok) return;
        tick(HP);
        for (int k = 0; k < 10; k++) begin
            dev_clk_low = 1'b1;
            tick(HP);
            got[k] = ps2_data;
            dev_clk_low = 1'b0;
            tick(HP);
        end
        if (ack) dev_data_low = 1'b1;
        tick(4);
        dev_pulses(1);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < IDLE_MAX) begin
            tick(1);
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic do_xfer(input logic [7:0] c, input bit ack,
                           output logic [9:0] got, output int dd,
                           output int de);
        int d0;
        int e0;
        bit ok;
        d0 = n_done;
        e0 = n_err;
        start_send(c);
        dev_xfer(ack, got, ok);
        check($sformatf("start bit seen %02h", c), ok, 1);
        wait_idle($sformatf("idle after %02h", c));
        tick(4);
        dd = n_done - d0;
        de = n_err - e0;
    endtask

    initial begin
        vec_t       tbl[6];
        logic [9:0] got;
        logic [7:0] c;
        bit         a;
        bit         ok;
        int         dd;
        int         de;
        int         d0;
        int         e0;
        int         n;

        tbl[0] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'hF4, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'h7E, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0};

        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        cmd  = 8'hED;
        send = 1'b1;
        RST  = 1'b1;
        #1 RST = 1'b0;

        // Reset holds everything quiet even with send asserted.
        repeat (3) @(negedge CLK50MHZ);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset error", error, 0);
        check("reset clk_oe", ps2_clk_oe, 0);
        check("reset data_oe", ps2_data_oe, 0);

        // First rising edge after release accepts the pending send.
        d0 = n_done;
        e0 = n_err;
        #2 RST = 1'b1;
        @(negedge CLK50MHZ);
        check("first edge busy", busy, 1);
        check("first edge clk_oe", ps2_clk_oe, 1);
        tick(1);
        send = 1'b0;
        dev_xfer(1'b1, got, ok);
        check("ED start bit seen", ok, 1);
        wait_idle("ED idle");
        tick(4);
        check("ED line bits", got, 10'h3ED);
        check("ED frame model", got, model_frame(8'hED));
        check("ED done once", n_done - d0, 1);
        check("ED no error", n_err - e0, 0);

        foreach (tbl[i]) begin
            do_xfer(tbl[i].cmd, tbl[i].ack, got, dd, de);
            check($sformatf("vec%0d parity", i), got[8], tbl[i].exp_par);
            check($sformatf("vec%0d frame", i), got, model_frame(tbl[i].cmd));
            check($sformatf("vec%0d done", i), dd, tbl[i].exp_done);
            check($sformatf("vec%0d error", i), de, tbl[i].exp_err);
        end

        // No device: inhibit, one-cycle start bit, then watchdog expiry.
        d0 = n_done;
        e0 = n_err;
        start_send(8'h5A);
        @(negedge CLK50MHZ);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
            n++;
            @(negedge CLK50MHZ);
        end
        check("inhibit cycles", n, INH);
        n = 0;
        while (ps2_clk_oe && ps2_data_oe && n < 10) begin
            n++;
            @(negedge CLK50MHZ);
        end
        check("start bit cycles", n, 1);
        n = 0;
        while (!ps2_clk_oe && ps2_data_oe && busy && n < TMO + 10) begin
            n++;
            @(negedge CLK50MHZ);
        end
        check("timeout cycles", n, TMO);
        check("timeout error high", error, 1);
        check("timeout clk_oe", ps2_clk_oe, 0);
        check("timeout data_oe", ps2_data_oe, 0);
        check("timeout busy", busy, 0);
        @(negedge CLK50MHZ);
        check("timeout error width", error, 0);
        tick(2);
        check("timeout no done", n_done - d0, 0);
        check("timeout one error", n_err - e0, 1);

        // Reset after the fourth data bit is on the line.
        d0 = n_done;
        e0 = n_err;
        start_send(8'h00);
        wait_send(ok);
        check("rst start bit seen", ok, 1);
        tick(HP);
        dev_pulses(4);
        check("rst d3 driven", ps2_data_oe, 1);
        @(negedge CLK50MHZ);
        #3 RST = 1'b0;
        #1;
        check("rst async clk_oe", ps2_clk_oe, 0);
        check("rst async data_oe", ps2_data_oe, 0);
        check("rst async busy", busy, 0);
        tick(3);
        RST = 1'b1;
        tick(2);
        check("rst no done", n_done - d0, 0);
        check("rst no error", n_err - e0, 0);
        do_xfer(8'hF4, 1'b1, got, dd, de);
        check("after rst F4 frame", got, model_frame(8'hF4));
        check("after rst F4 done", dd, 1);
        check("after rst F4 error", de, 0);

        // A second send mid-transfer must not disturb the latched byte.
        d0 = n_done;
        e0 = n_err;
        start_send(8'hA5);
        fork
            dev_xfer(1'b1, got, ok);
            begin
                tick(60);
                check("resend while busy", busy, 1);
                cmd  = 8'h3C;
                send = 1'b1;
                tick(1);
                send = 1'b0;
            end
        join
        check("resend start bit seen", ok, 1);
        wait_idle("resend idle");
        tick(4);
        check("resend frame", got, model_frame(8'hA5));
        check("resend done once", n_done - d0, 1);
        check("resend no error", n_err - e0, 0);
        tick(5);
        check("resend not queued", busy, 0);

        for (int i = 0; i < 8; i++) begin
            c = 8'($urandom_range(0, 255));
            a = 1'($urandom_range(0, 1));
            do_xfer(c, a, got, dd, de);
            check($sformatf("rnd%0d frame %02h", i, c), got, model_frame(c));
            check($sformatf("rnd%0d done", i), dd, a ? 1 : 0);
            check($sformatf("rnd%0d error", i), de, a ? 0 : 1);
        end

        check("done and error never together", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 5000: clock-low inhibit length in CLK50MHZ cycles (100 us).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 750000: maximum cycles between device clock falling edges (15 ms).
REQ-003 The block SHALL have port CLK50MHZ, input, 1 bit: the single clock; all logic rising-edge.
REQ-004 The block SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cmd, input, 8 bits: command byte, sampled only when send is accepted.
REQ-006 The block SHALL have port send, input, 1 bit: transmit request, acted on only in IDLE.
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse on acknowledged completion.
REQ-009 The block SHALL have port error, output, 1 bit: one-cycle pulse on timeout or missing ack.
REQ-010 The block SHALL have ports ps2_clk and ps2_data, inputs, 1 bit each: raw PS/2 lines, asynchronous.
REQ-011 The block SHALL have ports ps2_clk_oe and ps2_data_oe, outputs, 1 bit each: 1 drives the line low, 0 releases it (open-drain).

Function
REQ-012 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer; negedge = previous synced ps2_clk 1 and current 0, one-cycle pulse.
REQ-013 States SHALL be IDLE, INHIBIT, REQ, SEND, ACK, RELEASE; encoding free.
REQ-014 IDLE: both oe 0; send=1 latches cmd and odd parity (~^cmd) into a 10-bit frame {1, parity, cmd} and enters INHIBIT next cycle.
REQ-015 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-016 REQ: ps2_clk_oe=1, ps2_data_oe=1 (start bit) for exactly 1 cycle, then SEND with ps2_clk_oe=0 and ps2_data_oe held 1.
REQ-017 SEND: on each negedge the block SHALL present the next frame bit LSB first (data bits 0..7, parity, stop), ps2_data_oe = ~bit, updated the cycle after the negedge pulse.
REQ-018 After the 10th negedge in SEND (stop bit presented, ps2_data_oe=0) the block SHALL enter ACK.
REQ-019 ACK: on the next negedge, synced ps2_data=0 SHALL go to RELEASE; synced ps2_data=1 SHALL pulse error and return to IDLE.
REQ-020 RELEASE: wait until synced ps2_clk and ps2_data are both 1, then pulse done and return to IDLE.
REQ-021 A timeout counter SHALL clear on entry to SEND and on every negedge; reaching TIMEOUT_CYCLES in SEND, ACK or RELEASE SHALL pulse error, release both lines and return to IDLE in the same cycle.
REQ-022 send while busy=1 SHALL be ignored; the latched frame SHALL not change during a transfer.
REQ-023 done and error SHALL never assert together; at most one pulse per accepted send.
REQ-024 ps2_clk_oe and ps2_data_oe SHALL be registered outputs, glitch-free.
REQ-025 Counters SHALL be sized as clog2 of their parameter plus 1 and SHALL not wrap.

Reset
REQ-026 While RST=0, state SHALL be IDLE; busy, done, error, ps2_clk_oe and ps2_data_oe SHALL be 0; counters and synchronizers SHALL be cleared (synchronizers to 1).
REQ-027 Reset asserted mid-transfer SHALL release both lines immediately (asynchronously), with no done or error pulse.
REQ-028 After RST deasserts, the first send SHALL be accepted on the first rising clock edge.

Verification
REQ-029 The bench SHALL cover this scenario: cmd=0xED with a device model clocking at 12.5 kHz -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1 on the line; ack low -> done pulse once, busy low.
REQ-030 The bench SHALL cover this scenario: cmd=0x01 -> parity bit 0; cmd=0x00 -> parity bit 1; both complete with done.
REQ-031 The bench SHALL cover this scenario: send with no device clock -> ps2_clk_oe high for exactly 5000 cycles, start bit for 1 cycle, then error exactly 750000 cycles after SEND entry, both oe 0.
REQ-032 The bench SHALL cover this scenario: device holds ps2_data high at the 11th negedge -> error pulse, no done.
REQ-033 The bench SHALL cover this scenario: RST low after the 4th data bit -> both oe 0 asynchronously, busy 0; a subsequent send of 0xF4 completes normally.
REQ-034 The bench SHALL cover this scenario: send pulsed again during a transfer with a different cmd -> ignored; the transmitted byte equals the first cmd.
